clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//  Measures an externally generated slow clock on the system clock Clk, e.g. the
//  2 Hz output of the board clock divider or any off-board square wave.
//  Reports period and high time in Clk cycles, pulses Valid once per completed
//  period, and flags a stalled input.
//  It is the receiving end of the divided-clock interface and is used for
//  self-check and display.
// PARAMETERS
//  CNT_W          27           counter/result width; must satisfy TIMEOUT_CYCLES < 2**CNT_W
//  TIMEOUT_CYCLES 100_000_000  Clk cycles with no rising edge before Stalled (2 s @ 50 MHz)
//  SYNC_STAGES    2            synchronizer flops on Clk_in (>=2)
// PORTS
//  Clk        in   1      system clock; all logic on rising edge
//  nReset     in   1      reset, asynchronous, active-low
//  Clk_in     in   1      asynchronous slow clock under measurement
//  Enable     in   1      1 = measure; 0 = idle
//  Period     out  CNT_W  Clk cycles between last two accepted Clk_in rising edges
//  High_time  out  CNT_W  Clk cycles Clk_in was high within that period
//  Valid      out  1      one-cycle pulse; Period/High_time updated this cycle
//  Stalled    out  1      level; no rising edge within TIMEOUT_CYCLES
// BEHAVIOUR
//  - Reset: Period=0, High_time=0, Valid=0, Stalled=0, sync flops=0, counter=0, state IDLE.
//  - Clk_in passes SYNC_STAGES flops, then a prev-sample register.
//    rise = s & ~prev; fall = ~s & prev.
//  - FSM IDLE -> ARM -> MEAS:
//    IDLE: counter held at 0. Enable=1 -> ARM.
//    ARM: waits for rise. Falls are ignored. Rise -> MEAS with counter=0.
//      The first partial period is never reported.
//    MEAS: counter increments every cycle.
//      On fall: hi_lat <= counter+1.
//      On rise: Period <= counter+1, High_time <= hi_lat, Valid=1 next cycle,
//      Stalled <= 0, counter <= 0.
//  - Latency: Valid is high in cycle SYNC_STAGES+1 after the first Clk edge that samples Clk_in high.
//  - Timeout: in ARM or MEAS, counter == TIMEOUT_CYCLES-1 with no rise ->
//    Stalled <= 1, counter <= 0, state ARM. Period and High_time hold.
//    Counter never wraps.
//  - Stall recovery: Stalled clears on the next Valid. The first rise after a stall only re-arms.
//  - Enable=0 in any state -> IDLE next cycle, Valid=0, Stalled<=0.
//    Period and High_time hold last values.
//  - Simultaneous events:
//    Enable=0 and rise in the same cycle: Enable wins, no Valid.
//    Rise and timeout terminal count in the same cycle: rise wins, Valid, no Stalled.
//  - Clk_in high at reset release: the spurious rise from the zeroed sync flops only arms. No Valid.
//  - Async nReset mid-measurement: all outputs go to reset values immediately, and the FSM returns to IDLE.
//  - Valid is never asserted in two consecutive cycles.
//  - Minimum measurable period: 2*(SYNC_STAGES) Clk cycles. Shorter input is undefined.
// STRUCTURE
//  - Package clk_meter_pkg:
//    state encoding localparams ST_IDLE=2'd0, ST_ARM=2'd1, ST_MEAS=2'd2;
//    default CNT_W; TIMEOUT default.
//  - Sub-module sync_edge_detect (params SYNC_STAGES): synchronizer chain + prev register.
//    Outputs level, rise and fall; nReset clears all flops.
//  - Top: FSM, counter, hi_lat, output registers.
// TESTING (bench: Clk 10 ns, TIMEOUT_CYCLES=64, CNT_W=8)
//  1. Clk_in period 10 cycles, 5 high, Enable=1 -> after arm, Valid every 10 cycles.
//     Period=10, High_time=5. Latency after the Clk_in rise = SYNC_STAGES+1.
//  2. Period 10, 3 high, then change to period 16, 12 high ->
//     Valid reports 10/3, then the first full new period 16/12. No missed Valid.
//  3. Clk_in stuck low after a rise -> Stalled=1 exactly 64 cycles after the last rise.
//     Period holds. Restart -> first rise re-arms only. Next rise gives Valid and Stalled=0.
//  4. Enable=0 mid-period -> no Valid, outputs hold. Re-enable -> first reported Period is a full 10.
//  5. nReset low mid-measurement with Clk_in high -> all outputs 0 within the same cycle.
//     After release, no Valid until the second rise.
//  6. Rise coincident with terminal count (period exactly 64), and Enable drop coincident with rise ->
//     Period=64 with Valid and no Stalled. Enable-drop case gives no Valid.

Source files
------------

// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the clock period meter.
//   - default counter width and stall timeout
//   - FSM state encoding used by clock_period_meter
package clk_meter_pkg;

  // Default result width; must hold TIMEOUT_DEFAULT without wrapping.
  localparam int CNT_W_DEFAULT   = 27;
  // Clk cycles with no accepted rising edge before the input counts as stalled
  // (2 s at 50 MHz).
  localparam int TIMEOUT_DEFAULT = 100_000_000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ARM  = ST_ARM,
    MEAS = ST_MEAS
  } state_t;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchronizer and edge detector for the slow clock under measurement.
// Ports:
//   Clk     in  system clock
//   nReset  in  asynchronous active-low reset, clears every flop
//   Clk_in  in  asynchronous input
//   level   out synchronized level of Clk_in
//   rise    out one-cycle strobe, synchronized level went 0 -> 1
//   fall    out one-cycle strobe, synchronized level went 1 -> 0
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Clk_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Clk_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures a slow external clock in units of the system clock.
// Ports:
//   Clk        in  system clock, all logic on the rising edge
//   nReset     in  asynchronous active-low reset
//   Clk_in     in  asynchronous slow clock under measurement
//   Enable     in  1 = measure, 0 = idle (results hold)
//   Period     out Clk cycles between the last two accepted rising edges
//   High_time  out Clk cycles Clk_in was high within that period
//   Valid      out one-cycle strobe: Period/High_time were updated this cycle
//   Stalled    out level: no rising edge within TIMEOUT_CYCLES
// Valid is a plain strobe with no ready: the consumer samples Period and
// High_time in the cycle Valid is high; the values then hold until the next
// strobe, a reset, or forever if the input stops.
module clock_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             Clk_in,
  input  logic             Enable,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] High_time,
  output logic             Valid,
  output logic             Stalled
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             level;
  logic             rise;
  logic             fall;
  logic             unused_level;
  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] hi_lat;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clk   (Clk),
    .nReset(nReset),
    .Clk_in(Clk_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Only the edge strobes drive the measurement.
  assign unused_level = level;

  // The counter runs in ARM as well as MEAS so that a missing first edge
  // also raises Stalled. It is cleared on every accepted rise and at the
  // terminal count, so it never wraps.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      counter   <= '0;
      hi_lat    <= '0;
      Period    <= '0;
      High_time <= '0;
      Valid     <= 1'b0;
      Stalled   <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (!Enable) begin
        // Disable beats any simultaneous edge; results hold.
        state   <= IDLE;
        counter <= '0;
        Stalled <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            state   <= ARM;
          end
          ARM: begin
            // The first rise only marks the start of a full period.
            if (rise) begin
              state   <= MEAS;
              counter <= '0;
            end else if (counter == TERM) begin
              Stalled <= 1'b1;
              counter <= '0;
            end else begin
              counter <= counter + ONE;
            end
          end
          MEAS: begin
            // A rise on the terminal count is still a valid period.
            if (rise) begin
              Period    <= counter + ONE;
              High_time <= hi_lat;
              Valid     <= 1'b1;
              Stalled   <= 1'b0;
              counter   <= '0;
            end else if (counter == TERM) begin
              Stalled <= 1'b1;
              counter <= '0;
              state   <= ARM;
            end else begin
              counter <= counter + ONE;
              if (fall) begin
                hi_lat <= counter + ONE;
              end
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter (CNT_W=8, TIMEOUT_CYCLES=64,
// SYNC_STAGES=2). An event/timestamp model predicts every output each cycle.
module tb_clock_period_meter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int SYNC    = 2;

  logic             clk     = 1'b0;
  logic             n_reset = 1'b0;
  logic             clk_in  = 1'b0;
  logic             enable  = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stalled;

  clock_period_meter #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .Clk      (clk),
    .nReset   (n_reset),
    .Clk_in   (clk_in),
    .Enable   (enable),
    .Period   (period),
    .High_time(high_time),
    .Valid    (valid),
    .Stalled  (stalled)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int checks          = 0;
  int failures        = 0;
  int step_n          = 0;
  int valid_cnt       = 0;
  int last_valid_step = 0;

  // ---------------- reference model ----------------
  // Works on timestamps: m_ref is the edge index of the accepted reference
  // rise (-1 when none), m_win the start of the current timeout window.
  bit              m_q[$];
  bit              m_prev;
  bit              m_active;
  int              m_ref;
  int              m_win;
  int              m_hi;
  int              m_period;
  int              m_high;
  bit              m_valid;
  bit              m_stalled;
  int              edge_n = 0;
  logic [15:0]     exp_q[$];

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_prev    = 1'b0;
    m_active  = 1'b0;
    m_ref     = -1;
    m_win     = 0;
    m_hi      = 0;
    m_period  = 0;
    m_high    = 0;
    m_valid   = 1'b0;
    m_stalled = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input bit cin, input bit en);
    bit s;
    bit rise;
    bit fall;
    edge_n++;
    if (!n_reset) return;
    // Clk_in reaches the meter SYNC edges after it is sampled.
    s = m_q.pop_front();
    m_q.push_back(cin);
    rise   = s && !m_prev;
    fall   = !s && m_prev;
    m_prev = s;
    m_valid = 1'b0;
    if (!en) begin
      m_active  = 1'b0;
      m_ref     = -1;
      m_stalled = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_ref    = -1;
      m_win    = edge_n;
    end else if (rise) begin
      if (m_ref >= 0) begin
        m_period  = edge_n - m_ref;
        m_high    = m_hi;
        m_valid   = 1'b1;
        m_stalled = 1'b0;
        exp_q.push_back({8'(m_period), 8'(m_high)});
      end
      m_ref = edge_n;
      m_win = edge_n;
    end else if (edge_n - m_win == TIMEOUT) begin
      m_stalled = 1'b1;
      m_ref     = -1;
      m_win     = edge_n;
    end else if (fall && m_ref >= 0) begin
      m_hi = edge_n - m_ref;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change at the falling edge; outputs are compared at the next one.
  task automatic step(input bit cin, input bit en);
    logic [15:0] e;
    clk_in = cin;
    enable = en;
    @(posedge clk);
    model_edge(cin, en);
    @(negedge clk);
    step_n++;
    check("valid", valid, m_valid);
    check("stalled", stalled, m_stalled);
    check("period", period, m_period);
    check("high_time", high_time, m_high);
    if (valid === 1'b1) begin
      valid_cnt++;
      last_valid_step = step_n;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid: actual=valid expected=no valid at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_period", period, e[15:8]);
        check("sb_high", high_time, e[7:0]);
      end
    end
  endtask

  task automatic run_wave(input int per, input int hi, input int nper, input bit en);
    for (int p = 0; p < nper; p++)
      for (int c = 0; c < per; c++)
        step(c < hi, en);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    n_reset = 1'b0;
    #1;
    check("rst_async_period", period, 0);
    check("rst_async_high", high_time, 0);
    check("rst_async_valid", valid, 0);
    check("rst_async_stalled", stalled, 0);
    model_reset();
    @(negedge clk);
    step(clk_in, enable);
    step(clk_in, enable);
    n_reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int per;
    int hi;
    int nper;
    int exp_per;
    int exp_hi;
    int exp_valids;
  } vec_t;

  vec_t vecs[7];

  // ---------------- test ----------------
  initial begin
    int v0;
    int rs;
    int stall_step;
    int per;
    int hi;
    bit en;

    vecs[0] = '{10, 5, 3, 10, 5, 3};
    vecs[1] = '{10, 3, 4, 10, 3, 4};
    vecs[2] = '{16, 12, 3, 16, 12, 3};
    vecs[3] = '{6, 2, 5, 6, 2, 5};
    vecs[4] = '{40, 1, 2, 40, 1, 2};
    vecs[5] = '{4, 2, 6, 4, 2, 6};
    vecs[6] = '{7, 4, 3, 7, 4, 3};

    model_reset();
    n_reset = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("reset_period", period, 0);
    check("reset_high", high_time, 0);
    check("reset_valid", valid, 0);
    check("reset_stalled", stalled, 0);
    n_reset = 1'b1;

    // 1: 10/5 input, arm, then latency of the first report
    repeat (4) step(1'b0, 1'b1);
    v0 = valid_cnt;
    run_wave(10, 5, 1, 1'b1);
    check("arm_no_valid", valid_cnt - v0, 0);
    rs = step_n + 1;
    run_wave(10, 5, 1, 1'b1);
    check("latency_cycles", last_valid_step - rs + 1, SYNC + 1);
    check("first_period", period, 10);
    check("first_high", high_time, 5);
    v0 = valid_cnt;
    run_wave(10, 5, 3, 1'b1);
    check("steady_valids", valid_cnt - v0, 3);

    // 2: table of waveform changes
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      run_wave(vecs[i].per, vecs[i].hi, vecs[i].nper, 1'b1);
      check("tbl_valids", valid_cnt - v0, vecs[i].exp_valids);
      check("tbl_period", period, vecs[i].exp_per);
      check("tbl_high", high_time, vecs[i].exp_hi);
    end

    // 3: stuck low after a rise
    step(1'b1, 1'b1);
    rs = step_n;
    stall_step = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1);
      if (stalled === 1'b1 && stall_step == 0) stall_step = step_n;
    end
    // 64 cycles after the rise is seen, which is SYNC cycles after it is driven
    check("stall_delay", stall_step - rs, TIMEOUT + SYNC);
    check("stall_period_hold", period, 7);
    v0 = valid_cnt;
    run_wave(10, 5, 1, 1'b1);
    check("stall_rearm_valids", valid_cnt - v0, 0);
    check("stall_rearm_stalled", stalled, 1);
    v0 = valid_cnt;
    run_wave(10, 5, 1, 1'b1);
    check("stall_recover_valids", valid_cnt - v0, 1);
    check("stall_recover_stalled", stalled, 0);
    check("stall_recover_period", period, 10);

    // 4: Enable dropped mid-period
    run_wave(10, 5, 1, 1'b1);
    for (int c = 0; c < 4; c++) step(c < 5, 1'b1);
    v0 = valid_cnt;
    for (int c = 4; c < 10; c++) step(c < 5, 1'b0);
    run_wave(10, 5, 2, 1'b0);
    check("dis_valids", valid_cnt - v0, 0);
    check("dis_period_hold", period, 10);
    check("dis_high_hold", high_time, 5);
    check("dis_stalled", stalled, 0);
    v0 = valid_cnt;
    run_wave(10, 5, 2, 1'b1);
    check("reen_valids", valid_cnt - v0, 1);
    check("reen_period", period, 10);

    // 5: reset while Clk_in is high
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    do_reset();
    v0 = valid_cnt;
    repeat (3) step(1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b1);
    check("rst_spurious_rise_valids", valid_cnt - v0, 0);
    v0 = valid_cnt;
    run_wave(10, 5, 1, 1'b1);
    check("rst_second_rise_valids", valid_cnt - v0, 1);

    // 6a: period equal to the timeout
    v0 = valid_cnt;
    run_wave(64, 32, 3, 1'b1);
    check("tc_valids", valid_cnt - v0, 3);
    check("tc_period", period, 64);
    check("tc_high", high_time, 32);
    check("tc_stalled", stalled, 0);

    // 6b: Enable drops in the cycle the rise reaches the meter
    run_wave(10, 5, 1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    v0 = valid_cnt;
    step(1'b1, 1'b0);
    check("en_rise_valid", valid, 0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    check("en_rise_valids", valid_cnt - v0, 0);
    check("en_rise_period_hold", period, 64);

    // random waveforms, some longer than the timeout, occasional disable
    for (int i = 0; i < 40; i++) begin
      per = $urandom_range(4, 80);
      hi  = $urandom_range(1, per - 1);
      en  = ($urandom_range(0, 7) != 0);
      run_wave(per, hi, 1, en);
    end
    repeat (4) step(1'b0, 1'b1);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
